hit_rate_counter: RTL
=====================

// Module: hit_rate_counter
// PURPOSE
//  Consumer end of the one-second tick.
//  - Counts rising edges of i_hit inside each window bounded by i_sec_pulse.
//  - At each tick, reports the closed-window count through a valid/ack handshake.
//  - Keeps a running sum over the last HIST_DEPTH windows.
//  - Sits between the tick generator and the display/UART reporting logic.
// PARAMETERS
//  CNT_W      16  width of per-window hit count (saturating)
//  HIST_DEPTH 4   number of windows in rolling sum (>=2, power of 2 not required)
//  SUM_W      CNT_W+$clog2(HIST_DEPTH)  rolling-sum width (never overflows)
// PORTS
//  i_clk        in   1      clock
//  i_rst        in   1      reset: synchronous, active-high
//  i_sec_pulse  in   1      1-cycle window-close tick
//  i_hit        in   1      hit level; each 0->1 transition = one hit
//  i_rd_ack     in   1      consumer accepts o_cnt (meaningful only while o_cnt_vld=1)
//  o_cnt        out  CNT_W  count of last closed window
//  o_cnt_vld    out  1      o_cnt holds an unacknowledged report
//  o_win_sat    out  1      reported window saturated at 2^CNT_W-1
//  o_sum        out  SUM_W  sum of last HIST_DEPTH reported counts
//  o_hist_full  out  1      HIST_DEPTH windows collected since reset
//  o_ovf        out  1      sticky: a report was overwritten before ack
// BEHAVIOUR
//  Reset: all outputs 0; live count 0; history entries 0; hit-prev register = 1.
//   A level already high at reset does not count until it first goes low.
//  Edge detect: hit_edge = hit_s & ~hit_prev; hit_prev <= hit_s every cycle.
//  Live count:
//   - increments on hit_edge, saturating at all-ones.
//   - a per-window sat flag is set on any edge seen while at all-ones.
//  On i_sec_pulse (window close):
//   - a hit_edge in the same cycle belongs to the closing window.
//   - o_cnt <= final count; o_win_sat <= window sat flag.
//   - live count <= 0 and sat flag <= 0; the next window starts at 0.
//   - history shifts: o_sum <= o_sum + new - oldest; the oldest entry drops out.
//   - o_hist_full sets after the HIST_DEPTH-th tick and stays set.
//   - latency: outputs are updated one cycle after the tick.
//   - a tick with no edges reports 0 with o_cnt_vld=1; this is not suppressed.
//  Handshake FSM, 2 states:
//   EMPTY (o_cnt_vld=0) --tick--> FULL.
//   FULL  --ack, no tick--> EMPTY.
//   FULL  --tick & ack--> FULL: new data loaded, no overflow.
//   FULL  --tick, no ack--> FULL: data overwritten, o_ovf <= 1.
//   i_rd_ack in EMPTY is ignored.
//  o_cnt and o_sum stay stable while FULL, except when overwritten by a tick.
//  o_ovf clears only on reset.
//  Reset mid-window: the partial count is discarded, history is cleared, FSM goes to EMPTY.
//  Back-to-back ticks on consecutive cycles are legal; each closes its own window.
// CONFIGURATION
//  HIT_SYNC_EN defined:
//   - i_hit passes through a 2-flop synchronizer (reset 1) to form hit_s.
//   - adds 2 cycles of hit latency; a hit edge within 2 cycles before a tick counts
//     in the next window.
//   - i_hit may be asynchronous.
//  HIT_SYNC_EN undefined:
//   - hit_s = i_hit directly; i_hit must be synchronous to i_clk.
// TESTING (HIT_SYNC_EN undefined unless noted; defaults)
//  1. Reset, hold i_hit=1 for 5 cycles, then 3 clean hit pulses, then tick
//     -> o_cnt=3, o_cnt_vld=1, o_sum=3.
//  2. Hit edge on the same cycle as the tick -> it is counted in the closing window;
//     the next window starts at 0.
//  3. Ticks reporting 5, 7, 2, 4, 1
//     -> o_sum=5, 12, 14, 18, 14; o_hist_full rises on the 4th report.
//  4. Leave the report unacked across the next tick -> o_ovf=1 and o_cnt = newer value;
//     tick with simultaneous ack -> o_ovf stays 0.
//  5. CNT_W=4, 20 hits, then tick -> o_cnt=15, o_win_sat=1; next window with 2 hits
//     -> o_cnt=2, o_win_sat=0.
//  6. HIT_SYNC_EN defined: hit edge 1 cycle before the tick -> counted in the next
//     window. Reset asserted mid-window -> all outputs 0.

Source files
------------

// File: rtl/hit_rate_counter.sv
// Hit counter per one-second window with a valid/ack report, a rolling sum and sticky overflow.
// Define HIT_SYNC_EN to pass i_hit through a 2-flop synchronizer (i_hit may then be asynchronous).
module hit_rate_counter #(
    parameter int CNT_W      = 16,
    parameter int HIST_DEPTH = 4,
    parameter int SUM_W      = CNT_W + $clog2(HIST_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sec_pulse,
    input  logic             i_hit,
    input  logic             i_rd_ack,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_vld,
    output logic             o_win_sat,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_hist_full,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int               FILL_W  = $clog2(HIST_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(HIST_DEPTH - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic             hit_s;
    logic             hit_prev_reg;
    logic             hit_edge;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_final;
    logic             sat_reg, sat_next, sat_final;
    logic [CNT_W-1:0] out_cnt_reg;
    logic             out_sat_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [FILL_W-1:0] fill_reg;
    logic             full_reg;
    logic             ovf_reg;
    logic             cnt_vld;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hist_q [HIST_DEPTH];

`ifdef HIT_SYNC_EN
    logic [1:0] sync_reg;

    // Reset to 1 so a level already high at reset never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) sync_reg <= 2'b11;
        else       sync_reg <= {sync_reg[0], i_hit};
    end

    assign hit_s = sync_reg[1];
`else
    assign hit_s = i_hit;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) hit_prev_reg <= 1'b1;
        else       hit_prev_reg <= hit_s;
    end

    assign hit_edge = hit_s & ~hit_prev_reg;

    // Final count includes an edge arriving in the same cycle as the tick.
    always_comb begin
        cnt_final = cnt_reg;
        sat_final = sat_reg;
        if (hit_edge) begin
            if (cnt_reg == CNT_MAX) sat_final = 1'b1;
            else                    cnt_final = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_next = cnt_final;
        sat_next = sat_final;
        if (i_sec_pulse) begin
            cnt_next = '0;
            sat_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
            sat_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            sat_reg <= sat_next;
        end
    end

    // History shift register; entry 0 is the newest report.
    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            logic [CNT_W-1:0] ent_reg;
            logic [CNT_W-1:0] ent_in;

            if (gi == 0) begin : g_head
                assign ent_in = cnt_final;
            end else begin : g_tail
                assign ent_in = hist_q[gi-1];
            end

            always_ff @(posedge i_clk) begin
                if (i_rst)            ent_reg <= '0;
                else if (i_sec_pulse) ent_reg <= ent_in;
            end

            assign hist_q[gi] = ent_reg;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_cnt_reg <= '0;
            out_sat_reg <= 1'b0;
            sum_reg     <= '0;
            fill_reg    <= '0;
            full_reg    <= 1'b0;
        end else if (i_sec_pulse) begin
            out_cnt_reg <= cnt_final;
            out_sat_reg <= sat_final;
            sum_reg     <= sum_reg + SUM_W'(cnt_final) - SUM_W'(hist_q[HIST_DEPTH-1]);
            if (!full_reg) fill_reg <= fill_reg + FILL_W'(1);
            if (fill_reg == FILL_LAST) full_reg <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= EMPTY;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (i_sec_pulse) state_next = FULL;
            FULL:    if (i_rd_ack && !i_sec_pulse) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        cnt_vld = (state_reg == FULL);
    end

    // Overwrite of an unacknowledged report is sticky until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ovf_reg <= 1'b0;
        else if (i_sec_pulse && state_reg == FULL && !i_rd_ack)
            ovf_reg <= 1'b1;
    end

    assign o_cnt       = out_cnt_reg;
    assign o_cnt_vld   = cnt_vld;
    assign o_win_sat   = out_sat_reg;
    assign o_sum       = sum_reg;
    assign o_hist_full = full_reg;
    assign o_ovf       = ovf_reg;

endmodule
